// File: rtl/fifo_flagged.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_flagged #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enq,
  input  logic                    deq,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    err_clr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfC    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeC    = CntW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PtrW-1:0] rp_q, rp_d;
  logic [PtrW-1:0] wp_q, wp_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic wr_ok;
  logic rd_ok;

  // Flags decode only the count register, so they never see enq/deq directly.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthC);
  assign almost_full  = (count_q >= AfC);
  assign almost_empty = (count_q <= AeC);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_out     = mem[rp_q];

  // A write into a full FIFO is fine when the head leaves on the same edge.
  assign wr_ok = enq & (~full | deq);
  assign rd_ok = deq & ~empty;

  always_comb begin
    rp_d        = rp_q;
    wp_d        = wp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) wp_d = wp_q + PtrW'(1);
    if (rd_ok) rp_d = rp_q + PtrW'(1);

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Clear first, then a same-cycle error event sets the flag again.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (enq && !wr_ok) overflow_d  = 1'b1;
    if (deq && !rd_ok) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rp_q        <= '0;
      wp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rp_q        <= rp_d;
      wp_q        <= wp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; contents are only observable once written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp_q] <= data_in;
  end

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged (DEPTH=4, AF_LEVEL=3, AE_LEVEL=1): the driver
// queues expected pops and per-cycle status; an independent monitor checks them.
module tb_fifo_flagged;

  logic       clk;
  logic       rstn;
  logic       enq;
  logic       deq;
  logic [7:0] data_in;
  logic       err_clr;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  fifo_flagged #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .AF_LEVEL   (3),
    .AE_LEVEL   (1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enq          (enq),
    .deq          (deq),
    .data_in      (data_in),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  typedef struct {
    logic       enq;
    logic       deq;
    logic       clr;
    logic [7:0] din;
    logic       popv;   // a pop is expected this cycle
    logic [7:0] popd;   // word expected on data_out when popped
    logic [2:0] cnt;    // expected count after the edge
    logic [3:0] flg;    // expected {empty, almost_empty, almost_full, full} after the edge
    logic       ovf;
    logic       udf;
    logic       hv;     // check head word after the edge
    logic [7:0] head;
  } vec_t;

  typedef struct {
    int   due;
    vec_t v;
  } stat_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] data_q[$];
  stat_t      stat_q[$];
  vec_t       tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic d, input logic c, input logic [7:0] din,
                              input logic pv, input logic [7:0] pd, input logic [2:0] cnt,
                              input logic [3:0] flg, input logic ovf, input logic udf,
                              input logic hv, input logic [7:0] head);
    vec_t v;
    v.enq = e; v.deq = d; v.clr = c; v.din = din; v.popv = pv; v.popd = pd;
    v.cnt = cnt; v.flg = flg; v.ovf = ovf; v.udf = udf; v.hv = hv; v.head = head;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    stat_t s;
    @(posedge clk);
    #2;
    enq = v.enq; deq = v.deq; err_clr = v.clr; data_in = v.din;
    if (v.popv) data_q.push_back(v.popd);
    s.due = cyc + 1;
    s.v   = v;
    stat_q.push_back(s);
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    enq = 1'b0; deq = 1'b0; err_clr = 1'b0;
  endtask

  // Monitor: a pop is presented when deq is high and the FIFO is not empty.
  initial begin
    stat_t s;
    forever begin
      @(negedge clk);
      if (deq && !empty) begin
        if (data_q.size() == 0) chk("pop_unexpected", 32'(data_out), 32'hFFFF_FFFF);
        else chk("pop_data", 32'(data_out), 32'(data_q.pop_front()));
      end
      while (stat_q.size() > 0 && stat_q[0].due <= cyc) begin
        s = stat_q.pop_front();
        chk("count", 32'(count), 32'(s.v.cnt));
        chk("flags", 32'({empty, almost_empty, almost_full, full}), 32'(s.v.flg));
        chk("overflow", 32'(overflow), 32'(s.v.ovf));
        chk("underflow", 32'(underflow), 32'(s.v.udf));
        if (s.v.hv) chk("head", 32'(data_out), 32'(s.v.head));
      end
    end
  end

  initial begin
    logic [7:0] w[13];
    int         waited;

    rstn = 1'b1; enq = 1'b0; deq = 1'b0; err_clr = 1'b0; data_in = '0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    #10 rstn = 1'b1;

    // Fill, overflow, drain.
    tbl.push_back(mk(1, 0, 0, 8'h11, 0, 8'h00, 3'd1, 4'b0100, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h22, 0, 8'h00, 3'd2, 4'b0000, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h33, 0, 8'h00, 3'd3, 4'b0010, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h44, 0, 8'h00, 3'd4, 4'b0011, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h55, 0, 8'h00, 3'd4, 4'b0011, 1, 0, 1, 8'h11));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h11, 3'd3, 4'b0010, 1, 0, 1, 8'h22));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h22, 3'd2, 4'b0000, 1, 0, 1, 8'h33));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h33, 3'd1, 4'b0100, 1, 0, 1, 8'h44));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h44, 3'd0, 4'b1100, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 3'd0, 4'b1100, 0, 0, 0, 8'h00));
    // Refill, then enq+deq while full.
    tbl.push_back(mk(1, 0, 0, 8'h11, 0, 8'h00, 3'd1, 4'b0100, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h22, 0, 8'h00, 3'd2, 4'b0000, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h33, 0, 8'h00, 3'd3, 4'b0010, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h44, 0, 8'h00, 3'd4, 4'b0011, 0, 0, 1, 8'h11));
    tbl.push_back(mk(1, 1, 0, 8'hAA, 1, 8'h11, 3'd4, 4'b0011, 0, 0, 1, 8'h22));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h22, 3'd3, 4'b0010, 0, 0, 1, 8'h33));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h33, 3'd2, 4'b0000, 0, 0, 1, 8'h44));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h44, 3'd1, 4'b0100, 0, 0, 1, 8'hAA));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'hAA, 3'd0, 4'b1100, 0, 0, 0, 8'h00));
    // Underflow with same-cycle enq, clear, and set-wins-over-clear.
    tbl.push_back(mk(1, 1, 0, 8'h77, 0, 8'h00, 3'd1, 4'b0100, 0, 1, 1, 8'h77));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 3'd1, 4'b0100, 0, 0, 1, 8'h77));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h77, 3'd0, 4'b1100, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 3'd0, 4'b1100, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 3'd0, 4'b1100, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 3'd0, 4'b1100, 0, 0, 0, 8'h00));
    foreach (tbl[i]) drive(tbl[i]);

    // Pointer wrap: preload three words, then ten enq+deq pairs.
    for (int i = 0; i < 13; i++) w[i] = 8'($urandom_range(255));
    drive(mk(1, 0, 0, w[0], 0, 8'h00, 3'd1, 4'b0100, 0, 0, 1, w[0]));
    drive(mk(1, 0, 0, w[1], 0, 8'h00, 3'd2, 4'b0000, 0, 0, 1, w[0]));
    drive(mk(1, 0, 0, w[2], 0, 8'h00, 3'd3, 4'b0010, 0, 0, 1, w[0]));
    for (int i = 0; i < 10; i++)
      drive(mk(1, 1, 0, w[i+3], 1, w[i], 3'd3, 4'b0010, 0, 0, 1, w[i+1]));
    idle();
    @(negedge clk);
    #1;
    chk("pre_reset_count", 32'(count), 32'd3);

    // Asynchronous reset mid-burst: takes effect without a clock edge.
    rstn = 1'b0;
    #1;
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_full", 32'(full), 32'd0);
    #8 rstn = 1'b1;

    drive(mk(1, 0, 0, 8'h5A, 0, 8'h00, 3'd1, 4'b0100, 0, 0, 1, 8'h5A));
    drive(mk(0, 1, 0, 8'h00, 1, 8'h5A, 3'd0, 4'b1100, 0, 0, 0, 8'h00));
    idle();

    waited = 0;
    while ((data_q.size() != 0 || stat_q.size() != 0) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    chk("queues_drained", 32'(data_q.size() + stat_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
Synchronous single-clock FIFO that generalises the bus-path queue in the serial system bus. It uses all DEPTH entries, so full means exactly DEPTH words are stored. It adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags with a clear input. Read data is first-word-fall-through. It sits between bus master/slave ports and the serial link as a rate-decoupling buffer.

Parameters:
DATA_WIDTH, 8, width of each stored word (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
enq  input  1  write request
deq  input  1  read/pop request
data_in  input  DATA_WIDTH  write data, sampled on an accepted enq
err_clr  input  1  synchronous clear of overflow/underflow
data_out  output  DATA_WIDTH  head-of-queue word (FWFT); valid when !empty
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH
overflow  output  1  sticky: enq was rejected
underflow  output  1  sticky: deq was rejected

Behaviour:
- Reset (rstn low, asynchronous, takes effect immediately):
  - rp, wp and count go to 0.
  - overflow and underflow go to 0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), which is 0 for legal AF_LEVEL.
  - Memory contents are not reset; data_out is don't-care while empty.
- Release is synchronous to clk. The first accepted operation can occur at the first rising edge after rstn deasserts.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a separate register of $clog2(DEPTH)+1 bits.
- Flags:
  - All flags are combinational decodes of the count register only, so they change one cycle after the causing edge.
  - They are glitch-free relative to clk.
- Accept rules, evaluated on each rising edge:
  - wr_ok = enq & (!full | deq).
    - Writing while full is allowed when a deq happens in the same cycle.
  - rd_ok = deq & !empty.
    - A pop while empty is rejected even if enq is asserted in the same cycle. No bypass of data_in to data_out.
  - wr_ok: mem[wp] <= data_in; wp <= wp+1.
  - rd_ok: rp <= rp+1.
  - Count update:
    - wr_ok only: count+1.
    - rd_ok only: count-1.
    - Both or neither: count unchanged.
- data_out = mem[rp], combinational (FWFT).
  - A word written into an empty FIFO appears on data_out the cycle after the write edge, together with empty=0.
  - After rd_ok, data_out shows the next word in the cycle after the edge.
- Error flags:
  - enq & !wr_ok sets overflow on the edge.
  - deq & !rd_ok sets underflow on the edge.
  - Both flags are sticky until err_clr or reset.
  - If err_clr and a new error event occur in the same cycle, set wins: the flag stays 1.
  - A rejected operation leaves all pointers, count and memory unchanged.
- Reset asserted mid-operation discards all contents. Behaviour after release is identical to power-up.
- Latency:
  - Write to visible on data_out/flags: 1 cycle.
  - Pop to next word visible: 1 cycle.
  - No combinational path from enq/deq/data_in to any output.

Test Plan:
- Reset then idle; DEPTH=4, AF_LEVEL=3, AE_LEVEL=1 -> empty=1, almost_empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0.
- Fill: enq 0x11,0x22,0x33,0x44 on 4 edges -> count 1,2,3,4; almost_empty drops at count=2; almost_full rises at count=3; full=1 at 4; data_out=0x11 throughout.
- Full plus enq 0x55 without deq -> overflow=1, count stays 4. Then drain 4 pops -> data_out 0x11,0x22,0x33,0x44 in order; empty=1 after the 4th; 0x55 never appears.
- Simultaneous enq+deq when full, enq 0xAA -> count stays 4, full stays 1, no overflow. Pop 4 more -> 0x22,0x33,0x44,0xAA.
- Empty plus deq with enq 0x77 in the same cycle -> underflow=1, count=1, data_out=0x77 next cycle. err_clr pulse -> underflow=0. err_clr in the same cycle as a new underflow -> underflow stays 1.
- Wrap and reset: 10 enq/deq pairs with random data cross the pointer wrap with FIFO order preserved. Assert rstn low asynchronously mid-burst at count=3 -> empty=1 and count=0 immediately, without waiting for a clock edge.
